// File: rtl/fsm_lib_pkg.sv
// Shared types and helpers for the serial FSM detector library.
// Holds the scanner state encoding and a constant-width helper.
package fsm_lib_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } scan_state_t;

    // Number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ones_run_detect.sv
// Serial ones-run detector: tracks the current run, the longest run and
// how many runs reached MIN_RUN, one bit per enabled cycle.
module ones_run_detect
    import fsm_lib_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MIN_RUN = 2,
    parameter int CNT_W   = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic             det,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] run_count,
    output logic [CNT_W-1:0] max_run
);

    logic             prev_bit;
    logic [CNT_W-1:0] run_inc;

    assign run_inc = (run_len == CNT_W'(WIDTH)) ? run_len : run_len + 1'b1;
    assign det     = en & bit_in & prev_bit;

    // A run is counted on the bit that makes it exactly MIN_RUN long, so a
    // run that reaches the MSB is counted without needing a trailing zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_bit  <= 1'b0;
            run_len   <= '0;
            run_count <= '0;
            max_run   <= '0;
        end else if (clr) begin
            prev_bit  <= 1'b0;
            run_len   <= '0;
            run_count <= '0;
            max_run   <= '0;
        end else if (en) begin
            prev_bit <= bit_in;
            if (bit_in) begin
                run_len <= run_inc;
                if (run_inc == CNT_W'(MIN_RUN)) begin
                    run_count <= run_count + 1'b1;
                end
                if (run_inc > max_run) begin
                    max_run <= run_inc;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule

// File: rtl/ones_run_scanner.sv
// Accepts a word over valid/ready, shifts it LSB-first through the ones-run
// detector and holds the run statistics until the consumer takes them.
module ones_run_scanner
    import fsm_lib_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MIN_RUN = 2,
    parameter int CNT_W   = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] run_count,
    output logic [CNT_W-1:0] max_run,
    output logic             busy,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             det
);

    scan_state_t      state;
    scan_state_t      state_n;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] idx;
    logic             accept;
    logic             last_bit;
    logic             det_clr;
    logic [CNT_W-1:0] det_count;
    logic [CNT_W-1:0] det_max;
    logic [CNT_W-1:0] unused_run_len;

    assign accept    = (state == IDLE) & in_valid & ~abort;
    assign last_bit  = (idx == CNT_W'(WIDTH - 1));
    assign det_clr   = accept | ((state != IDLE) & abort) | ((state == DONE) & out_ready);

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign ser_valid = (state == SHIFT);
    assign ser_bit   = sreg[0];

    // Counters are only meaningful once the scan has finished.
    assign run_count = out_valid ? det_count : '0;
    assign max_run   = out_valid ? det_max   : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) state_n = SHIFT;
            end
            SHIFT: begin
                if (abort)         state_n = IDLE;
                else if (last_bit) state_n = DONE;
            end
            DONE: begin
                if (abort || out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The shift register is emptied on abort so a cancelled word never
    // leaks onto ser_bit while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            idx  <= '0;
        end else if (accept) begin
            sreg <= in_data;
            idx  <= '0;
        end else if (state == SHIFT) begin
            if (abort) begin
                sreg <= '0;
                idx  <= '0;
            end else begin
                sreg <= sreg >> 1;
                idx  <= last_bit ? '0 : idx + 1'b1;
            end
        end
    end

    ones_run_detect #(
        .WIDTH   (WIDTH),
        .MIN_RUN (MIN_RUN),
        .CNT_W   (CNT_W)
    ) u_detect (
        .clk       (clk),
        .rst       (rst),
        .clr       (det_clr),
        .en        (ser_valid),
        .bit_in    (ser_bit),
        .det       (det),
        .run_len   (unused_run_len),
        .run_count (det_count),
        .max_run   (det_max)
    );

endmodule

// File: tb/tb_ones_run_scanner.sv
// Randomised and directed checks of ones_run_scanner against a run-length
// reference model; a second instance runs with MIN_RUN = 1.
module tb_ones_run_scanner;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          abort;
    logic          out_ready;

    logic          in_ready, out_valid, busy, ser_valid, ser_bit, det;
    logic [CW-1:0] run_count, max_run;
    logic          in_ready1, out_valid1, busy1, ser_valid1, ser_bit1, det1;
    logic [CW-1:0] run_count1, max_run1;

    int checkCount;
    int passCount;

    ones_run_scanner #(.WIDTH(W), .MIN_RUN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .run_count (run_count),
        .max_run   (max_run),
        .busy      (busy),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .det       (det)
    );

    ones_run_scanner #(.WIDTH(W), .MIN_RUN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .run_count (run_count1),
        .max_run   (max_run1),
        .busy      (busy1),
        .ser_valid (ser_valid1),
        .ser_bit   (ser_bit1),
        .det       (det1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    // Walks maximal runs directly: a run is judged when it ends.
    function automatic void refModel(input logic [W-1:0] w, input int minRun,
                                     output int cnt, output int mx, output logic [63:0] detv);
        int len;
        len  = 0;
        cnt  = 0;
        mx   = 0;
        detv = '0;
        for (int i = 0; i < W; i++) begin
            if (w[i]) begin
                len++;
                if (len > mx) mx = len;
                if (i > 0 && w[i-1]) detv[i] = 1'b1;
            end else begin
                if (len >= minRun) cnt++;
                len = 0;
            end
        end
        if (len >= minRun) cnt++;
    endfunction

    // stopIdx: -1 full scan, 0..W-1 abort/reset on that bit, W abort in DONE.
    task automatic applyStimulus(input logic [W-1:0] word, input int holdCycles,
                                 input int stopIdx, input bit useRst);
        int expCnt, expMax, expCnt1, expMax1;
        logic [63:0] expDet, expDet1;
        logic [63:0] obsSer, obsDet, obsDet1;
        int validCnt, earlyValid, holdErr, lateValid;
        logic [W-1:0] junk;

        refModel(word, 2, expCnt, expMax, expDet);
        refModel(word, 1, expCnt1, expMax1, expDet1);
        obsSer = '0; obsDet = '0; obsDet1 = '0;
        validCnt = 0; earlyValid = 0; holdErr = 0; lateValid = 0;

        in_data  = word;
        in_valid = 1'b1;
        checkOutput("in_ready_offer", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        junk     = W'($urandom);
        in_data  = junk;

        for (int i = 0; i < W; i++) begin
            if (i == stopIdx) begin
                if (useRst) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("rst_busy", busy, 0);
                    checkOutput("rst_in_ready", in_ready, 1);
                    checkOutput("rst_ser_valid", ser_valid, 0);
                    checkOutput("rst_out_valid", out_valid, 0);
                    @(negedge clk);
                    rst = 1'b0;
                end else begin
                    abort = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    abort = 1'b0;
                    checkOutput("abort_busy", busy, 0);
                    checkOutput("abort_in_ready", in_ready, 1);
                    checkOutput("abort_run_count", run_count, 0);
                end
                for (int k = 0; k < 2 * W; k++) begin
                    lateValid += out_valid + out_valid1;
                    @(negedge clk);
                end
                checkOutput("stop_no_out_valid", lateValid, 0);
                return;
            end
            obsSer[i]  = ser_bit;
            obsDet[i]  = det;
            obsDet1[i] = det1;
            validCnt  += ser_valid;
            earlyValid += out_valid;
            @(posedge clk);
            @(negedge clk);
        end

        checkOutput("ser_bits", obsSer, 64'(word));
        checkOutput("det_vec", obsDet, expDet);
        checkOutput("det_vec_min1", obsDet1, expDet1);
        checkOutput("ser_valid_cycles", validCnt, W);
        checkOutput("early_out_valid", earlyValid, 0);
        checkOutput("out_valid_latency", out_valid, 1);
        checkOutput("done_ser_valid", ser_valid, 0);
        checkOutput("done_in_ready", in_ready, 0);
        checkOutput("run_count", run_count, expCnt);
        checkOutput("max_run", max_run, expMax);
        checkOutput("run_count_min1", run_count1, expCnt1);
        checkOutput("max_run_min1", max_run1, expMax1);

        if (stopIdx == W) begin
            abort     = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            abort     = 1'b0;
            out_ready = 1'b0;
            checkOutput("done_abort_out_valid", out_valid, 0);
            checkOutput("done_abort_run_count", run_count, 0);
            checkOutput("done_abort_busy", busy, 0);
            return;
        end

        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                run_count !== CW'(expCnt) || max_run !== CW'(expMax)) holdErr++;
        end
        checkOutput("backpressure_hold", holdErr, 0);

        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("release_out_valid", out_valid, 0);
        checkOutput("release_in_ready", in_ready, 1);
        checkOutput("idle_run_count", run_count, 0);
        checkOutput("idle_max_run", max_run, 0);
    endtask

    initial begin
        logic [W-1:0] rw;
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ser_valid", ser_valid, 0);
        checkOutput("reset_ser_bit", ser_bit, 0);
        checkOutput("reset_det", det, 0);
        checkOutput("reset_run_count", run_count, 0);
        checkOutput("reset_max_run", max_run, 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'h0000, 0, -1, 1'b0);
        applyStimulus(16'hFFFF, 0, -1, 1'b0);
        applyStimulus(16'h0666, 0, -1, 1'b0);
        applyStimulus(16'h5555, 0, -1, 1'b0);
        applyStimulus(16'h8001, 0, -1, 1'b0);
        applyStimulus(16'h0F3C, 10, -1, 1'b0);
        applyStimulus(16'hFFFF, 0, 5, 1'b0);
        applyStimulus(16'hFFFF, 0, 5, 1'b1);
        applyStimulus(16'hFFFF, 0, -1, 1'b0);
        applyStimulus(16'h00F0, 0, W, 1'b0);

        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_abort_busy", busy, 0);
        checkOutput("idle_abort_in_ready", in_ready, 1);
        in_valid = 1'b0;
        abort    = 1'b0;

        for (int n = 0; n < 40; n++) begin
            rw = W'($urandom);
            applyStimulus(rw, int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
